stack_ctrl: RTL

Stack-pointer and top-of-stack controller sitting directly upstream of a mem instance used as the data stack. It drives that memory's addr/in/wen.
- Caches TOS and NOS in registers; deeper entries spill to memory.
- Executes one stack op per handshake and flags overflow/underflow.
- The instruction decoder issues ops to it; the ALU reads tos/nos.

---
 rtl/stack_ctrl_pkg.sv | 21 ++
 rtl/stack_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared constants for the data-stack controller: default widths, opcodes and FSM states.
package stack_ctrl_pkg;

  localparam int DEFAULT_STACK_WIDTH     = 16;
  localparam int DEFAULT_DATA_STACK_SIZE = 4;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_REPL  = 3'd6;
  localparam logic [2:0] OP_REPL2 = 3'd7;

  typedef enum logic {
    ST_RDY,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Data-stack controller: TOS/NOS cached in registers, deeper entries spilled to an
// external registered-read memory that is kept prefetched at mem[sp-1].
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int STACK_WIDTH     = DEFAULT_STACK_WIDTH,
  parameter int DATA_STACK_SIZE = DEFAULT_DATA_STACK_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op,
  input  logic [STACK_WIDTH-1:0]     din,
  output logic [STACK_WIDTH-1:0]     tos,
  output logic [STACK_WIDTH-1:0]     nos,
  output logic [DATA_STACK_SIZE+1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic [DATA_STACK_SIZE-1:0] mem_addr,
  output logic [STACK_WIDTH-1:0]     mem_in,
  output logic                       mem_wen,
  input  logic [STACK_WIDTH-1:0]     mem_out
);

  localparam int DW = DATA_STACK_SIZE + 2;
  localparam int CAP = (1 << DATA_STACK_SIZE) + 2;
  localparam logic [DW-1:0] CAP_D = DW'(CAP);
  localparam logic [DW-1:0] TWO_D = DW'(2);

  state_t state, next_state;
  logic [DATA_STACK_SIZE:0] sp;

  logic                   accept;
  logic                   is_push;
  logic                   is_pop;
  logic                   do_swap;
  logic                   do_repl;
  logic                   do_ovf;
  logic                   do_unf;
  logic                   two_plus;
  logic                   spill;
  logic                   fill;
  logic [STACK_WIDTH-1:0] push_val;

  assign op_ready = (state == ST_RDY);
  assign accept   = op_valid && op_ready;
  assign empty    = (depth == '0);
  assign full     = (depth == CAP_D);
  assign two_plus = (depth >= TWO_D);

  // Decode the accepted op into one action class; illegal ops become error pulses.
  always_comb begin
    is_push  = 1'b0;
    is_pop   = 1'b0;
    do_swap  = 1'b0;
    do_repl  = 1'b0;
    do_ovf   = 1'b0;
    do_unf   = 1'b0;
    push_val = din;
    if (accept) begin
      case (op)
        OP_NOP: ;
        OP_PUSH: is_push = 1'b1;
        OP_DUP: begin
          if (empty) do_unf = 1'b1;
          else begin
            is_push  = 1'b1;
            push_val = tos;
          end
        end
        OP_OVER: begin
          if (!two_plus) do_unf = 1'b1;
          else begin
            is_push  = 1'b1;
            push_val = nos;
          end
        end
        OP_POP:   if (empty) do_unf = 1'b1; else is_pop = 1'b1;
        OP_REPL2: if (!two_plus) do_unf = 1'b1; else is_pop = 1'b1;
        OP_SWAP:  if (!two_plus) do_unf = 1'b1; else do_swap = 1'b1;
        OP_REPL:  if (empty) do_unf = 1'b1; else do_repl = 1'b1;
      endcase
      if (is_push && full) begin
        is_push = 1'b0;
        do_ovf  = 1'b1;
      end
    end
  end

  assign spill    = is_push && two_plus;
  assign fill     = is_pop && (depth > TWO_D);
  assign mem_wen  = spill;
  assign mem_in   = nos;
  // Idle address sits at sp-1 so the next pop finds NOS refill data already in mem_out.
  assign mem_addr = spill ? sp[DATA_STACK_SIZE-1:0]
                          : sp[DATA_STACK_SIZE-1:0] - 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RDY;
    else     state <= next_state;
  end

  // One bubble after any sp change lets the registered read reload mem[sp-1].
  always_comb begin
    next_state = state;
    case (state)
      ST_RDY:    if (spill || fill) next_state = ST_SETTLE;
      ST_SETTLE: next_state = ST_RDY;
      default:   next_state = ST_RDY;
    endcase
  end

  // Datapath: TOS/NOS registers, depth and memory pointer, sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tos     <= '0;
      nos     <= '0;
      depth   <= '0;
      sp      <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (do_ovf) err_ovf <= 1'b1;
      if (do_unf) err_unf <= 1'b1;
      if (is_push) begin
        nos   <= tos;
        tos   <= push_val;
        depth <= depth + 1'b1;
        if (spill) sp <= sp + 1'b1;
      end else if (is_pop) begin
        if (op == OP_REPL2)       tos <= din;
        else if (depth == DW'(1)) tos <= '0;
        else                      tos <= nos;
        if (fill) begin
          nos <= mem_out;
          sp  <= sp - 1'b1;
        end else begin
          nos <= '0;
        end
        depth <= depth - 1'b1;
      end else if (do_swap) begin
        tos <= nos;
        nos <= tos;
      end else if (do_repl) begin
        tos <= din;
      end
    end
  end

endmodule
